// File: rtl/mem_wb_pkg.sv
// Shared encodings for the memory/writeback stage: access sizes, jump_type
// bit positions, FSM states and byte-lane helpers.
package mem_wb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int JT_BRANCH = 2;
    localparam int JT_BNE    = 1;
    localparam int JT_JUMP   = 0;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    // Byte enables for up to 8 lanes; narrower datapaths use the low lanes.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    byte_en = 8'h01 << off;
            SZ_H:    byte_en = 8'h03 << off;
            SZ_W:    byte_en = 8'h0F << off;
            default: byte_en = 8'hFF;
        endcase
    endfunction

    // Dword accesses only exist on a 64-bit datapath.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off,
                                        input logic is64);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = |off[1:0];
            default: misaligned = !is64 || (|off);
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_ram.sv
// Byte-enabled synchronous RAM. Read data appears MEM_LAT cycles after the
// address is presented; contents are never cleared.
module mem_wb_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [MEM_LAT];

    // Per-lane write so partial stores leave neighbouring bytes intact.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read every cycle and shift through the latency pipeline.
    always_ff @(posedge clk) begin
        pipe[0] <= mem[addr];
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: loads/stores into an internal RAM,
// branch/jump resolution and a registered writeback bundle.
// Optional build macro: MEM_WB_FWD_EN adds fwd_valid/fwd_reg/fwd_data, a
// combinational copy of the non-load bundle being registered this cycle.
//
// state        | meaning
// ST_IDLE      | ready for a bundle; non-loads complete in one cycle
// ST_LOAD_WAIT | RAM read in flight; counter runs down from MEM_LAT
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int PC_W    = 5,
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_target,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [2:0]        in_jump_type,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic              in_reg_we,
    input  logic [REG_W-1:0]  in_wr_reg,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              misalign
`ifdef MEM_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic              ready_q;

    logic [REG_W-1:0]  ld_reg;
    logic              ld_we;
    logic              ld_uns;
    logic              ld_mis;
    logic [1:0]        ld_size;
    logic [OFF_W-1:0]  ld_off;

    logic              accept;
    logic              is_load;
    logic              is_store;
    logic              mis;
    logic              zero;
    logic              taken;
    logic [OFF_W-1:0]  off;
    logic [2:0]        off3;
    logic [ADDR_W-1:0] widx;
    logic [NB-1:0]     be;
    logic              ram_we;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] ld_sh;
    logic [DATA_W-1:0] ld_ext;
    logic              ld_sgn;

    // The PC is carried for debug visibility only.
    logic unused_pc;
    assign unused_pc = ^in_pc;

    assign in_ready = ready_q;
    assign accept   = in_valid && ready_q;
    assign is_store = in_mem_wr;
    assign is_load  = in_mem_rd && !in_mem_wr;
    assign off      = in_alu_res[OFF_W-1:0];
    assign off3     = 3'(off);
    assign mis      = (in_mem_rd || in_mem_wr) && misaligned(in_size, off3, DATA_W == 64);
    assign widx     = in_alu_res[ADDR_W+OFF_W-1:OFF_W];
    assign be       = NB'(byte_en(in_size, off3));
    assign st_wdata = in_store_data << {off, 3'b000};
    assign ram_we   = accept && is_store && !mis;
    assign zero     = (in_alu_res == '0);
    assign cnt_nxt  = cnt - 3'd1;

    // Branch/jump decision from the ALU zero flag.
    always_comb begin
        taken = 1'b0;
        if (in_jump_type[JT_BRANCH]) taken = in_jump_type[JT_BNE] ? !zero : zero;
        else                         taken = in_jump_type[JT_JUMP];
    end

    mem_wb_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (be),
        .addr (widx),
        .wdata(st_wdata),
        .rdata(rdata)
    );

    // Align the addressed lane to bit 0 and sign/zero extend by size.
    assign ld_sh = rdata >> {ld_off, 3'b000};
    always_comb begin
        ld_sgn = 1'b0;
        ld_ext = ld_sh;
        case (ld_size)
            SZ_B: begin
                ld_sgn      = !ld_uns && ld_sh[7];
                ld_ext      = {DATA_W{ld_sgn}};
                ld_ext[7:0] = ld_sh[7:0];
            end
            SZ_H: begin
                ld_sgn       = !ld_uns && ld_sh[15];
                ld_ext       = {DATA_W{ld_sgn}};
                ld_ext[15:0] = ld_sh[15:0];
            end
            SZ_W: begin
                ld_sgn       = !ld_uns && ld_sh[31];
                ld_ext       = {DATA_W{ld_sgn}};
                ld_ext[31:0] = ld_sh[31:0];
            end
            default: ld_ext = ld_sh;
        endcase
    end

    // Control FSM with registered writeback, redirect and ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ready_q     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_reg_we   <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            misalign    <= 1'b0;
            ld_reg      <= '0;
            ld_we       <= 1'b0;
            ld_uns      <= 1'b0;
            ld_mis      <= 1'b0;
            ld_size     <= '0;
            ld_off      <= '0;
        end else begin
            wb_valid  <= 1'b0;
            wb_reg_we <= 1'b0;
            redirect  <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        redirect <= taken;
                        if (taken) redirect_pc <= in_target;
                        if (is_load) begin
                            state   <= ST_LOAD_WAIT;
                            cnt     <= 3'(MEM_LAT);
                            ready_q <= 1'b0;
                            ld_reg  <= in_wr_reg;
                            ld_we   <= in_reg_we;
                            ld_uns  <= in_unsigned;
                            ld_mis  <= mis;
                            ld_size <= in_size;
                            ld_off  <= off;
                        end else begin
                            wb_valid  <= 1'b1;
                            wb_reg_we <= in_reg_we && !mis;
                            wb_reg    <= in_wr_reg;
                            wb_data   <= in_alu_res;
                            misalign  <= mis;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state     <= ST_IDLE;
                        ready_q   <= 1'b1;
                        wb_valid  <= 1'b1;
                        wb_reg_we <= ld_we && !ld_mis;
                        wb_reg    <= ld_reg;
                        wb_data   <= ld_mis ? '0 : ld_ext;
                        misalign  <= ld_mis;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_WB_FWD_EN
    // EX-stage bypass of the non-load bundle accepted this cycle.
    always_comb begin
        fwd_valid = accept && !is_load && in_reg_we && !mis;
        fwd_reg   = in_wr_reg;
        fwd_data  = in_alu_res;
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised memory/writeback pipeline stage; successor to the single-cycle memory/writeback stage.
- Sits between the execute stage and the register file.
- Performs data-memory loads and stores with byte/half/word sizes and a configurable synchronous RAM latency.
- Resolves branches and jumps, and presents a registered writeback bundle plus a pipeline redirect/flush.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- ADDR_W, 8, word-address bits of the internal RAM (depth = 2**ADDR_W words).
- PC_W, 5, program-counter width.
- REG_W, 5, register-index width.
- MEM_LAT, 1, RAM read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  execute-stage bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_pc  in  PC_W  PC of the instruction.
- in_target  in  PC_W  jump/branch target.
- in_alu_res  in  DATA_W  ALU result / byte address.
- in_store_data  in  DATA_W  store data.
- in_jump_type  in  3  [2]=branch, [1]=1 bne / 0 beq, [0]=unconditional jump (used only when [2]=0).
- in_mem_rd  in  1  load.
- in_mem_wr  in  1  store.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
- in_unsigned  in  1  zero-extend load.
- in_reg_we  in  1  writes a register.
- in_wr_reg  in  REG_W  destination register.
- wb_valid  out  1  writeback bundle valid (one cycle per instruction).
- wb_reg_we  out  1  register-file write enable.
- wb_reg  out  REG_W  destination register.
- wb_data  out  DATA_W  writeback data.
- redirect  out  1  taken jump/branch; single-cycle pulse.
- redirect_pc  out  PC_W  redirect target.
- misalign  out  1  misaligned access pulse.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; in_ready = 1 the cycle after reset deasserts. RAM contents are not cleared.
- FSM states: IDLE, LOAD_WAIT.
- IDLE with in_valid:
  - Non-load: completes immediately. wb_* and redirect are registered, so they are valid the next cycle. Latency 1.
  - Store: writes the RAM in the accept cycle, using byte enables derived from in_size and the low address bits.
  - Load: goes to LOAD_WAIT. A counter is loaded with MEM_LAT.
- LOAD_WAIT:
  - in_ready = 0.
  - The counter decrements each cycle; at zero the load result is extracted, extended and registered, and the FSM returns to IDLE.
  - Load latency = MEM_LAT+1 cycles from accept to wb_valid.
- in_ready = 1 in IDLE only. No back-to-back accept during a load.
- Branch resolution uses zero = (in_alu_res == 0):
  - beq taken iff zero.
  - bne taken iff !zero.
  - jump_type[2]=0: taken iff jump_type[0].
  - A taken branch or jump drives redirect=1 and redirect_pc=in_target in the cycle after accept.
- Address map:
  - Word index = in_alu_res[ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)].
  - Upper address bits are ignored, so accesses wrap within the RAM depth.
- Misaligned access: the address is not a multiple of the access size.
  - Store is suppressed; load returns 0.
  - misalign pulses with wb_valid; wb_reg_we is forced to 0.
- Simultaneous load and store flags (in_mem_rd & in_mem_wr): treated as a store; the load is ignored.
- in_size=3 with DATA_W=32 is treated as misaligned.
- rst during LOAD_WAIT: the load is abandoned; wb_valid is never raised for it.

Optional Feature:
- MEM_WB_FWD_EN defined:
  - Adds output fwd_valid (1), fwd_reg (REG_W) and fwd_data (DATA_W).
  - These combinationally mirror the bundle being registered for non-load instructions in the accept cycle, for EX-stage bypass.
  - fwd_valid = 0 during LOAD_WAIT and for loads.
- MEM_WB_FWD_EN undefined: the ports are absent; no bypass logic.

Decomposition:
- Package mem_wb_pkg:
  - Size encodings SZ_B, SZ_H, SZ_W, SZ_D.
  - jump_type bit indices.
  - FSM state enum.
  - Function computing byte-enables from size and offset.
- One sub-module, mem_wb_ram: byte-enabled synchronous RAM with MEM_LAT-deep read pipeline, parametrised on DATA_W and ADDR_W.

Test Plan:
1. Store then load (defaults): sw 0xDEADBEEF to address 0x10, then lw from 0x10 → wb_data 0xDEADBEEF, wb_valid 2 cycles after the load is accepted, in_ready low for 1 cycle.
2. Byte lanes and extension: sb 0x80 to 0x13; lb from 0x13 → 0xFFFFFF80; lbu → 0x00000080; lw from 0x10 → 0x80ADBEEF.
3. Branch resolution:
   - beq (jump_type=3'b100) with alu_res=0 → redirect=1, redirect_pc=in_target.
   - bne (3'b110) with alu_res=0 → redirect=0.
   - jump (3'b001) → redirect=1.
4. Misalignment: lh at 0x11 → misalign=1, wb_reg_we=0, wb_data=0; sw to 0x12 leaves memory unchanged.
5. MEM_LAT=3 sweep: load is accepted → in_ready low for 3 cycles, wb_valid at cycle 4; a second in_valid held during the wait is accepted only after the return to IDLE.
6. Reset mid-load: rst asserted in LOAD_WAIT → wb_valid stays 0, in_ready=1 the cycle after rst falls, all outputs are 0.
